// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two read ports, an optional zero entry,
// optional write-to-read bypass, optional registered reads and a one-word-per-cycle clear sweep.
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          RD_REG   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wrenable,
  input  logic [ADDR_W-1:0] wraddr,
  input  logic [WIDTH-1:0]  wrdata,
  input  logic [ADDR_W-1:0] rdaddr0,
  input  logic [ADDR_W-1:0] rdaddr1,
  output logic [WIDTH-1:0]  rddata0,
  output logic [WIDTH-1:0]  rddata1,
  input  logic              clear,
  output logic              busy
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IdxLast = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_val  [2];

  assign busy  = (state_q == StSweep);
  // A write only commits outside the sweep and never to a hardwired zero entry.
  assign wr_en = wrenable && !busy && !(ZERO_REG && (wraddr == '0));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (idx_q == IdxLast) begin
          state_d = StIdle;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (busy) begin
      mem_q[idx_q] <= '0;
    end else if (wr_en) begin
      mem_q[wraddr] <= wrdata;
    end
  end

  assign rd_addr[0] = rdaddr0;
  assign rd_addr[1] = rdaddr1;

  // Zero entry overrides bypass; bypass overrides stored contents.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = mem_q[rd_addr[p]];
      if (BYPASS && wr_en && (wraddr == rd_addr[p])) begin
        rd_val[p] = wrdata;
      end
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_val[p] = '0;
      end
    end
  end

  if (RD_REG) begin : g_rd_reg
    logic [WIDTH-1:0] rd_q [2];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q[0] <= '0;
        rd_q[1] <= '0;
      end else begin
        rd_q[0] <= rd_val[0];
        rd_q[1] <= rd_val[1];
      end
    end

    assign rddata0 = rd_q[0];
    assign rddata1 = rd_q[1];
  end else begin : g_rd_comb
    assign rddata0 = rd_val[0];
    assign rddata1 = rd_val[1];
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: four parameter variants share one stimulus stream
// and are compared against an array-based reference model.
module tb_regfile_param;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wrenable = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [AW-1:0] rdaddr0 = '0;
  logic [AW-1:0] rdaddr1 = '0;
  logic [W-1:0]  wrdata = '0;

  logic [W-1:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c, rd0_d, rd1_d;
  logic         busy_a, busy_b, busy_c, busy_d;

  // a: zero/bypass/comb, b: plain comb, c: zero/bypass/registered, d: zero/registered read-first
  regfile_param u_dut_a (
    .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .rdaddr0(rdaddr0), .rdaddr1(rdaddr1), .rddata0(rd0_a), .rddata1(rd1_a),
    .clear(clear), .busy(busy_a)
  );
  regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0), .RD_REG(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .rdaddr0(rdaddr0), .rdaddr1(rdaddr1), .rddata0(rd0_b), .rddata1(rd1_b),
    .clear(clear), .busy(busy_b)
  );
  regfile_param #(.ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b1)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .rdaddr0(rdaddr0), .rdaddr1(rdaddr1), .rddata0(rd0_c), .rddata1(rd1_c),
    .clear(clear), .busy(busy_c)
  );
  regfile_param #(.ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b1)) u_dut_d (
    .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .wraddr(wraddr), .wrdata(wrdata),
    .rdaddr0(rdaddr0), .rdaddr1(rdaddr1), .rddata0(rd0_d), .rddata1(rd1_d),
    .clear(clear), .busy(busy_d)
  );

  initial forever #5 clk = ~clk;

  // Reference model: word arrays for zero-entry and plain variants, sweep timed by edge count.
  logic [W-1:0] mem_z [D];
  logic [W-1:0] mem_n [D];
  bit           sweeping;
  int           edges;
  int           sweep_start;
  int           checks = 0;
  int           errors = 0;
  int           n;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input logic [AW-1:0] a, input bit zero,
                                            input bit byp);
    bit eff = wrenable && !sweeping && !(zero && (wraddr == '0));
    if (zero && (a == '0)) return '0;
    if (byp && eff && (wraddr == a)) return wrdata;
    return zero ? mem_z[a] : mem_n[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mem_z[i] = '0;
      mem_n[i] = '0;
    end
    sweeping    = 1'b0;
    edges       = 0;
    sweep_start = 0;
  endtask

  // Called just after a negedge with inputs applied; checks, advances one edge, checks again.
  task automatic cycle();
    logic [W-1:0] ec0, ec1, ed0, ed1;
    int k;
    #1;
    check_val("busy_a", W'(busy_a), W'(sweeping));
    check_val("busy_b", W'(busy_b), W'(sweeping));
    check_val("busy_c", W'(busy_c), W'(sweeping));
    check_val("busy_d", W'(busy_d), W'(sweeping));
    check_val("rd0_a", rd0_a, exp_read(rdaddr0, 1'b1, 1'b1));
    check_val("rd1_a", rd1_a, exp_read(rdaddr1, 1'b1, 1'b1));
    check_val("rd0_b", rd0_b, exp_read(rdaddr0, 1'b0, 1'b0));
    check_val("rd1_b", rd1_b, exp_read(rdaddr1, 1'b0, 1'b0));
    ec0 = exp_read(rdaddr0, 1'b1, 1'b1);
    ec1 = exp_read(rdaddr1, 1'b1, 1'b1);
    ed0 = exp_read(rdaddr0, 1'b1, 1'b0);
    ed1 = exp_read(rdaddr1, 1'b1, 1'b0);
    if (sweeping) begin
      k = edges - sweep_start;
      mem_z[k] = '0;
      mem_n[k] = '0;
      if (k == D - 1) sweeping = 1'b0;
    end else begin
      if (wrenable) begin
        mem_n[wraddr] = wrdata;
        if (wraddr != '0) mem_z[wraddr] = wrdata;
      end
      if (clear) begin
        sweeping    = 1'b1;
        sweep_start = edges + 1;
      end
    end
    edges++;
    @(posedge clk);
    #1;
    check_val("rd0_c", rd0_c, ec0);
    check_val("rd1_c", rd1_c, ec1);
    check_val("rd0_d", rd0_d, ed0);
    check_val("rd1_d", rd1_d, ed1);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    wrenable = 1'b0;
    clear    = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_rd0_a", rd0_a, '0);
    check_val("rst_rd1_a", rd1_a, '0);
    check_val("rst_rd0_b", rd0_b, '0);
    check_val("rst_rd0_c", rd0_c, '0);
    check_val("rst_rd1_c", rd1_c, '0);
    check_val("rst_rd0_d", rd0_d, '0);
    check_val("rst_rd1_d", rd1_d, '0);
    check_val("rst_busy", W'(busy_a), '0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic count_sweep(input string tag);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy_a) break;
      n++;
      wrenable = (i == 3);
      wraddr   = 5'd9;
      wrdata   = 32'h0000_FFFF;
      clear    = (i == 5);
      rdaddr0  = 5'd9;
      rdaddr1  = AW'(i);
      cycle();
    end
    wrenable = 1'b0;
    clear    = 1'b0;
    check_val(tag, W'(n), W'(D));
  endtask

  initial begin
    model_reset();
    #3;
    check_val("por_busy", W'(busy_a), '0);
    check_val("por_rd0_c", rd0_c, '0);
    #4 reset_n = 1'b1;
    @(negedge clk);

    // All words read zero after reset
    for (int i = 0; i < D; i++) begin
      rdaddr0 = AW'(i);
      rdaddr1 = AW'(D - 1 - i);
      #1 check_val("reset_word", rd0_b, '0);
      cycle();
    end

    // Basic write and dual-port read
    wrenable = 1'b1; wraddr = 5'd5; wrdata = 32'hDEAD_BEEF; rdaddr0 = 5'd1;
    cycle();
    wrenable = 1'b0; rdaddr0 = 5'd5; rdaddr1 = 5'd5;
    #1;
    check_val("wr5_p0", rd0_a, 32'hDEAD_BEEF);
    check_val("wr5_p1", rd1_a, 32'hDEAD_BEEF);
    cycle();

    // Write to entry 0
    wrenable = 1'b1; wraddr = 5'd0; wrdata = 32'h1234_5678; rdaddr0 = 5'd0;
    cycle();
    wrenable = 1'b0;
    #1;
    check_val("zero_reg", rd0_a, '0);
    check_val("no_zero_reg", rd0_b, 32'h1234_5678);
    cycle();

    // Same-cycle bypass versus plain read
    wrenable = 1'b1; wraddr = 5'd7; wrdata = 32'hA5A5_A5A5; rdaddr0 = 5'd7;
    #1;
    check_val("bypass_same", rd0_a, 32'hA5A5_A5A5);
    check_val("nobypass_old", rd0_b, '0);
    cycle();
    wrenable = 1'b0;
    #1 check_val("nobypass_next", rd0_b, 32'hA5A5_A5A5);
    cycle();

    // Registered reads: write-first versus read-first
    wrenable = 1'b1; wraddr = 5'd3; wrdata = 32'h11; rdaddr1 = 5'd3;
    cycle();
    wrdata = 32'h22;
    cycle();
    wrenable = 1'b0;
    check_val("rdreg_wfirst", rd1_c, 32'h22);
    check_val("rdreg_rfirst", rd1_d, 32'h11);

    rdaddr0 = 5'd5;
    mid_reset();

    // Fill with addresses, then sweep
    for (int i = 0; i < D; i++) begin
      wrenable = 1'b1; wraddr = AW'(i); wrdata = W'(i); rdaddr0 = AW'(i); rdaddr1 = AW'(i);
      cycle();
    end
    wrenable = 1'b0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    count_sweep("busy_len");
    for (int i = 0; i < D; i++) begin
      rdaddr0 = AW'(i);
      rdaddr1 = AW'(i);
      #1 check_val("post_clear", rd0_b, '0);
      cycle();
    end

    // Partial sweep interrupted by reset, then a full sweep
    for (int i = 0; i < D; i++) begin
      wrenable = 1'b1; wraddr = AW'(i); wrdata = ~W'(i);
      cycle();
    end
    wrenable = 1'b0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    repeat (10) cycle();
    mid_reset();
    #1 check_val("busy_after_rst", W'(busy_a), '0);
    for (int i = 0; i < D; i++) begin
      rdaddr0 = AW'(i);
      rdaddr1 = AW'(D - 1 - i);
      cycle();
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    count_sweep("busy_len_2");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      wrenable = ($urandom_range(0, 3) != 0);
      wraddr   = AW'($urandom_range(0, D - 1));
      wrdata   = $urandom;
      rdaddr0  = ($urandom_range(0, 3) == 0) ? wraddr : AW'($urandom_range(0, D - 1));
      rdaddr1  = ($urandom_range(0, 3) == 0) ? wraddr : AW'($urandom_range(0, D - 1));
      clear    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clear    = 1'b0;
    wrenable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
